// File: rtl/exc_pkg.sv
// Shared exception codes and state/selector enums for the MEM-stage exception commit unit.
package exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_ACK = 2'd2
  } exc_state_t;

  // Which address feeds BadVAddr for the winning exception.
  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_IF   = 2'd1,
    BV_DATA = 2'd2
  } bv_sel_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: exception flags plus pending interrupt -> {any, excode, badvaddr source}.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       int_pend,
  input  logic       adel_if,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
  input  logic       adel_ld,
  input  logic       ades,
  output logic       any,
  output logic [4:0] excode,
  output bv_sel_t    bv_sel
);

  always_comb begin
    any    = 1'b1;
    excode = EXC_INT;
    bv_sel = BV_NONE;
    if (int_pend) begin
      excode = EXC_INT;
    end else if (adel_if) begin
      excode = EXC_ADEL;
      bv_sel = BV_IF;
    end else if (ri) begin
      excode = EXC_RI;
    end else if (ov) begin
      excode = EXC_OV;
    end else if (sys) begin
      excode = EXC_SYS;
    end else if (bp) begin
      excode = EXC_BP;
    end else if (adel_ld) begin
      excode = EXC_ADEL;
      bv_sel = BV_DATA;
    end else if (ades) begin
      excode = EXC_ADES;
      bv_sel = BV_DATA;
    end else begin
      any = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit.sv
// MEM-stage exception/ERET commit: drains outstanding data responses, commits once to CP0, kills until redirect ack.
// Optional EXC_INT_PEND_REG_EN registers the interrupt-pending term (one extra cycle of recognition latency).
module exc_commit
  import exc_pkg::*;
#(
  parameter int OUTS_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_valid,
  input  logic [31:0] ms_pc,
  input  logic        ms_bd,
  input  logic        ms_adel_if,
  input  logic        ms_ri,
  input  logic        ms_ov,
  input  logic        ms_sys,
  input  logic        ms_bp,
  input  logic        ms_adel_ld,
  input  logic        ms_ades,
  input  logic        ms_eret,
  input  logic [31:0] ms_if_badvaddr,
  input  logic [31:0] ms_data_addr,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic        data_req,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic        redirect_ack,
  output logic        ms_stall,
  output logic        ms_kill,
  output logic        mem_req_block,
  output logic        cp0_ex,
  output logic        cp0_bd,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_pc,
  output logic [31:0] cp0_badvaddr,
  output logic        eret_flush,
  output logic [1:0]  state_dbg
);

  localparam logic [OUTS_W-1:0] OUTS_MAX = '1;
  localparam logic [OUTS_W-1:0] OUTS_ONE = {{(OUTS_W-1){1'b0}}, 1'b1};

  exc_state_t        state, state_nxt;
  logic [OUTS_W-1:0] outs;
  logic              outs_zero, inc, dec;
  logic              int_raw, int_pend, ex_any, eret_ev, ev;
  logic [4:0]        enc_excode;
  bv_sel_t           enc_bv_sel;
  logic [31:0]       enc_badvaddr;
  logic [4:0]        hold_excode;
  logic [31:0]       hold_pc, hold_badvaddr;
  logic              hold_bd, hold_eret;

  assign int_raw = (|(cause_ip & status_im)) & status_ie & ~status_exl;

`ifdef EXC_INT_PEND_REG_EN
  logic int_pend_q;
  always_ff @(posedge clk) begin
    if (!resetn || state == WAIT_ACK) int_pend_q <= 1'b0;
    else                              int_pend_q <= int_raw;
  end
  assign int_pend = int_pend_q & ms_valid;
`else
  assign int_pend = int_raw & ms_valid;
`endif

  exc_prio_enc u_prio (
    .int_pend (int_pend),
    .adel_if  (ms_valid & ms_adel_if),
    .ri       (ms_valid & ms_ri),
    .ov       (ms_valid & ms_ov),
    .sys      (ms_valid & ms_sys),
    .bp       (ms_valid & ms_bp),
    .adel_ld  (ms_valid & ms_adel_ld),
    .ades     (ms_valid & ms_ades),
    .any      (ex_any),
    .excode   (enc_excode),
    .bv_sel   (enc_bv_sel)
  );

  always_comb begin
    case (enc_bv_sel)
      BV_IF:   enc_badvaddr = ms_if_badvaddr;
      BV_DATA: enc_badvaddr = ms_data_addr;
      default: enc_badvaddr = 32'h0;
    endcase
  end

  // Exceptions always take precedence over ERET.
  assign eret_ev = ms_valid & ms_eret & ~ex_any;
  assign ev      = ex_any | eret_ev;

  // A data_ok with nothing outstanding is ignored.
  assign outs_zero = (outs == '0);
  assign inc       = data_req & data_addr_ok;
  assign dec       = data_data_ok & ~outs_zero;

  always_ff @(posedge clk) begin
    if (!resetn)                               outs <= '0;
    else if (inc && !dec && outs != OUTS_MAX)  outs <= outs + OUTS_ONE;
    else if (dec && !inc)                      outs <= outs - OUTS_ONE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_excode   <= '0;
      hold_pc       <= '0;
      hold_bd       <= 1'b0;
      hold_badvaddr <= '0;
      hold_eret     <= 1'b0;
    end else if (state == IDLE && ev && !outs_zero) begin
      hold_excode   <= enc_excode;
      hold_pc       <= ms_pc;
      hold_bd       <= ms_bd;
      hold_badvaddr <= enc_badvaddr;
      hold_eret     <= eret_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (ev) state_nxt = outs_zero ? WAIT_ACK : DRAIN;
      DRAIN:    if (outs_zero) state_nxt = WAIT_ACK;
      WAIT_ACK: if (redirect_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ms_stall     = 1'b0;
    ms_kill      = 1'b0;
    cp0_ex       = 1'b0;
    cp0_bd       = 1'b0;
    cp0_excode   = '0;
    cp0_pc       = '0;
    cp0_badvaddr = '0;
    eret_flush   = 1'b0;
    case (state)
      IDLE: begin
        if (ev && outs_zero) begin
          cp0_ex     = ex_any;
          eret_flush = eret_ev;
          if (ex_any) begin
            cp0_excode   = enc_excode;
            cp0_pc       = ms_pc;
            cp0_bd       = ms_bd;
            cp0_badvaddr = enc_badvaddr;
          end
        end else if (ev) begin
          ms_stall = 1'b1;
        end
      end
      DRAIN: begin
        ms_stall = 1'b1;
        if (outs_zero) begin
          cp0_ex     = ~hold_eret;
          eret_flush = hold_eret;
          if (!hold_eret) begin
            cp0_excode   = hold_excode;
            cp0_pc       = hold_pc;
            cp0_bd       = hold_bd;
            cp0_badvaddr = hold_badvaddr;
          end
        end
      end
      WAIT_ACK: ms_kill = 1'b1;
      default: ;
    endcase
  end

  assign mem_req_block = (outs == OUTS_MAX) | ev | (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_exc_commit.sv
// Directed self-checking bench for exc_commit with a commit scoreboard.
module tb_exc_commit;

  logic        clk, resetn;
  logic        ms_valid, ms_bd, ms_adel_if, ms_ri, ms_ov, ms_sys, ms_bp, ms_adel_ld, ms_ades, ms_eret;
  logic [31:0] ms_pc, ms_if_badvaddr, ms_data_addr;
  logic        status_ie, status_exl;
  logic [7:0]  status_im, cause_ip;
  logic        data_req, data_addr_ok, data_data_ok, redirect_ack;
  logic        ms_stall, ms_kill, mem_req_block, cp0_ex, cp0_bd, eret_flush;
  logic [4:0]  cp0_excode;
  logic [31:0] cp0_pc, cp0_badvaddr;
  logic [1:0]  state_dbg;

  int tests  = 0;
  int failed = 0;
  logic [5:0] exp_q[$];  // {is_eret, excode} per expected commit

  exc_commit #(.OUTS_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .ms_valid(ms_valid), .ms_pc(ms_pc), .ms_bd(ms_bd),
    .ms_adel_if(ms_adel_if), .ms_ri(ms_ri), .ms_ov(ms_ov), .ms_sys(ms_sys),
    .ms_bp(ms_bp), .ms_adel_ld(ms_adel_ld), .ms_ades(ms_ades), .ms_eret(ms_eret),
    .ms_if_badvaddr(ms_if_badvaddr), .ms_data_addr(ms_data_addr),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im), .cause_ip(cause_ip),
    .data_req(data_req), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .redirect_ack(redirect_ack),
    .ms_stall(ms_stall), .ms_kill(ms_kill), .mem_req_block(mem_req_block),
    .cp0_ex(cp0_ex), .cp0_bd(cp0_bd), .cp0_excode(cp0_excode),
    .cp0_pc(cp0_pc), .cp0_badvaddr(cp0_badvaddr), .eret_flush(eret_flush),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    ms_valid = 0; ms_pc = 0; ms_bd = 0;
    ms_adel_if = 0; ms_ri = 0; ms_ov = 0; ms_sys = 0; ms_bp = 0;
    ms_adel_ld = 0; ms_ades = 0; ms_eret = 0;
    ms_if_badvaddr = 0; ms_data_addr = 0;
    data_req = 0; data_addr_ok = 0; data_data_ok = 0; redirect_ack = 0;
  endtask

  task automatic finish_redirect(input string tag);
    redirect_ack = 1;
    step();
    redirect_ack = 0;
    #1;
    chk({tag, "_idle"}, state_dbg, 0);
    chk({tag, "_nokill"}, ms_kill, 0);
  endtask

  // Every commit seen must match the head of the expected queue.
  always @(negedge clk) begin
    if (resetn && (cp0_ex || eret_flush)) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $error("FAIL commit_unexpected observed ex=%0b eret=%0b expected none", cp0_ex, eret_flush);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        assert ({eret_flush, cp0_excode} === e && !(cp0_ex && eret_flush)) else begin
          failed++;
          $error("FAIL commit_seq observed=%0b/%0b/0x%02h expected=0x%02h", cp0_ex, eret_flush, cp0_excode, e);
        end
      end
    end
  end

  initial begin
    resetn = 0;
    clear_all();
    status_ie = 0; status_exl = 0; status_im = 0; cause_ip = 0;
    repeat (3) step();
    chk("rst_stall", ms_stall, 0);
    chk("rst_kill", ms_kill, 0);
    chk("rst_mrb", mem_req_block, 0);
    chk("rst_ex", cp0_ex, 0);
    chk("rst_eret", eret_flush, 0);
    chk("rst_state", state_dbg, 0);
    resetn = 1;
    step();

    // OV with nothing outstanding: commits in the same cycle; same-cycle ack ignored
    ms_valid = 1; ms_ov = 1; ms_pc = 32'hBFC00100; redirect_ack = 1;
    exp_q.push_back(6'h0c);
    #1;
    chk("ov_ex", cp0_ex, 1);
    chk("ov_code", cp0_excode, 5'h0c);
    chk("ov_pc", cp0_pc, 32'hBFC00100);
    chk("ov_bv", cp0_badvaddr, 0);
    chk("ov_bd", cp0_bd, 0);
    chk("ov_mrb", mem_req_block, 1);
    chk("ov_kill0", ms_kill, 0);
    step();
    clear_all();
    #1;
    chk("ov_kill1", ms_kill, 1);
    chk("ov_state", state_dbg, 2);
    chk("ov_noex", cp0_ex, 0);
    step();
    chk("ov_kill2", ms_kill, 1);
    finish_redirect("ov");

    // EXL masks the interrupt
    status_ie = 1; status_exl = 1; status_im = 8'h80; cause_ip = 8'h80;
    step();
    ms_valid = 1;
    #1;
    chk("exl_noex", cp0_ex, 0);
    chk("exl_mrb", mem_req_block, 0);
    clear_all();
    status_exl = 0;
    step();

    // Interrupt beats SYS, delay-slot flag forwarded
    ms_valid = 1; ms_sys = 1; ms_bd = 1; ms_pc = 32'h00000100;
    exp_q.push_back(6'h00);
    #1;
    chk("int_ex", cp0_ex, 1);
    chk("int_code", cp0_excode, 5'h00);
    chk("int_bd", cp0_bd, 1);
    step();
    clear_all();
    status_ie = 0; status_im = 0; cause_ip = 0;
    #1;
    chk("int_once", cp0_ex, 0);
    finish_redirect("int");

    // Two loads outstanding, then ADES: stall until drained
    data_req = 1; data_addr_ok = 1;
    step();
    step();
    data_req = 0; data_addr_ok = 0;
    #1;
    chk("outs2_mrb", mem_req_block, 0);
    ms_valid = 1; ms_ades = 1; ms_data_addr = 32'h80000003; ms_pc = 32'h00000200;
    exp_q.push_back(6'h05);
    #1;
    chk("ades_stall", ms_stall, 1);
    chk("ades_noex", cp0_ex, 0);
    chk("ades_mrb", mem_req_block, 1);
    step();
    ms_data_addr = 32'h12345678; data_data_ok = 1;
    #1;
    chk("ades_drain", state_dbg, 1);
    chk("ades_noex1", cp0_ex, 0);
    step();
    chk("ades_noex2", cp0_ex, 0);
    chk("ades_stall2", ms_stall, 1);
    step();
    data_data_ok = 0;
    #1;
    chk("ades_ex", cp0_ex, 1);
    chk("ades_code", cp0_excode, 5'h05);
    chk("ades_bv", cp0_badvaddr, 32'h80000003);
    chk("ades_pc", cp0_pc, 32'h00000200);
    chk("ades_stall3", ms_stall, 1);
    step();
    clear_all();
    #1;
    chk("ades_kill", ms_kill, 1);
    chk("ades_once", cp0_ex, 0);
    finish_redirect("ades");

    // ERET alone
    ms_valid = 1; ms_eret = 1;
    exp_q.push_back(6'h20);
    #1;
    chk("eret_flush", eret_flush, 1);
    chk("eret_noex", cp0_ex, 0);
    chk("eret_pc0", cp0_pc, 0);
    step();
    clear_all();
    #1;
    chk("eret_once", eret_flush, 0);
    chk("eret_kill", ms_kill, 1);
    finish_redirect("eret");

    // ERET with RI: exception wins
    ms_valid = 1; ms_eret = 1; ms_ri = 1;
    exp_q.push_back(6'h0a);
    #1;
    chk("eretri_ex", cp0_ex, 1);
    chk("eretri_code", cp0_excode, 5'h0a);
    chk("eretri_noflush", eret_flush, 0);
    step();
    clear_all();
    finish_redirect("eretri");

    // Fetch ADEL beats RI and OV, BadVAddr from fetch address
    ms_valid = 1; ms_adel_if = 1; ms_ri = 1; ms_ov = 1;
    ms_if_badvaddr = 32'hBFC00123; ms_data_addr = 32'h80000000;
    exp_q.push_back(6'h04);
    #1;
    chk("adelif_code", cp0_excode, 5'h04);
    chk("adelif_bv", cp0_badvaddr, 32'hBFC00123);
    step();
    clear_all();
    finish_redirect("adelif");

    // BP beats load ADEL, BadVAddr is 0
    ms_valid = 1; ms_bp = 1; ms_adel_ld = 1; ms_data_addr = 32'h80000011;
    exp_q.push_back(6'h09);
    #1;
    chk("bp_code", cp0_excode, 5'h09);
    chk("bp_bv", cp0_badvaddr, 0);
    step();
    clear_all();
    finish_redirect("bp");

    // Load ADEL alone, BadVAddr from data address
    ms_valid = 1; ms_adel_ld = 1; ms_data_addr = 32'h80000011;
    exp_q.push_back(6'h04);
    #1;
    chk("adelld_code", cp0_excode, 5'h04);
    chk("adelld_bv", cp0_badvaddr, 32'h80000011);
    step();
    clear_all();
    finish_redirect("adelld");

    // Counter: simultaneous accept+response at 1 holds; third accept saturates
    data_req = 1; data_addr_ok = 1;
    step();
    data_data_ok = 1;
    step();
    data_data_ok = 0;
    step();
    chk("cnt2_mrb", mem_req_block, 0);
    step();
    data_req = 0; data_addr_ok = 0;
    #1;
    chk("cnt3_mrb", mem_req_block, 1);

    // Reset while draining drops the pending commit
    ms_valid = 1; ms_adel_ld = 1; ms_data_addr = 32'h00000004;
    #1;
    chk("rd_stall", ms_stall, 1);
    step();
    chk("rd_drain", state_dbg, 1);
    resetn = 0;
    clear_all();
    step();
    chk("rd_state", state_dbg, 0);
    chk("rd_stall0", ms_stall, 0);
    chk("rd_kill0", ms_kill, 0);
    chk("rd_ex0", cp0_ex, 0);
    chk("rd_mrb0", mem_req_block, 0);
    resetn = 1;
    data_data_ok = 1;
    repeat (3) step();
    data_data_ok = 0;
    chk("rd_after_state", state_dbg, 0);
    chk("rd_after_ex", cp0_ex, 0);
    step();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
